// File: rtl/bp_cce_mshr_bank_pkg.sv
// Shared types for the multi-entry CCE MSHR bank: coherence states, the
// one-hot field-select encoding, and the per-entry MSHR record.
package bp_cce_mshr_bank_pkg;

    localparam int paddr_width_p        = 40;
    localparam int lce_id_width_p       = 6;
    localparam int lce_assoc_p          = 8;
    localparam int lce_assoc_width_p    = $clog2(lce_assoc_p);
    localparam int block_offset_width_p = 6;
    localparam int num_flags_p          = 16;
    localparam int data_width_p         = 64;
    localparam int msg_size_width_lp    = 3;
    localparam int mshr_fields_lp       = 11;

    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    // One-hot so that a field mask is simply an OR of these values.
    typedef enum logic [mshr_fields_lp-1:0] {
        e_mshr_lce       = 11'h001,
        e_mshr_paddr     = 11'h002,
        e_mshr_way       = 11'h004,
        e_mshr_lru_way   = 11'h008,
        e_mshr_lru_paddr = 11'h010,
        e_mshr_lru_coh   = 11'h020,
        e_mshr_owner_lce = 11'h040,
        e_mshr_owner_way = 11'h080,
        e_mshr_owner_coh = 11'h100,
        e_mshr_next_coh  = 11'h200,
        e_mshr_msg_size  = 11'h400
    } bp_cce_mshr_field_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]    lce_id;
        logic [paddr_width_p-1:0]     paddr;
        logic [lce_assoc_width_p-1:0] way_id;
        logic [lce_assoc_width_p-1:0] lru_way_id;
        logic [paddr_width_p-1:0]     lru_paddr;
        bp_coh_states_e               lru_coh_state;
        logic [lce_id_width_p-1:0]    owner_lce_id;
        logic [lce_assoc_width_p-1:0] owner_way_id;
        bp_coh_states_e               owner_coh_state;
        bp_coh_states_e               next_coh_state;
        logic [msg_size_width_lp-1:0] msg_size;
        logic [num_flags_p-1:0]       flags;
    } bp_cce_mshr_s;

    function automatic logic field_en(logic [mshr_fields_lp-1:0] mask, bp_cce_mshr_field_e f);
        return |(mask & f);
    endfunction

    function automatic bp_cce_mshr_s mshr_init(logic [lce_id_width_p-1:0]    lce_id,
                                               logic [paddr_width_p-1:0]     paddr,
                                               logic [lce_assoc_width_p-1:0] lru_way_id,
                                               logic [num_flags_p-1:0]       flags);
        bp_cce_mshr_s m;
        m                = '0;
        m.lce_id         = lce_id;
        m.paddr          = paddr;
        m.lru_way_id     = lru_way_id;
        m.flags          = flags;
        m.next_coh_state = e_COH_I;
        return m;
    endfunction

endpackage

// File: rtl/bp_cce_mshr_bank_if.sv
// Signal bundle between the CCE ucode stage (master) and the MSHR bank (slave).
interface bp_cce_mshr_bank_if #(parameter int num_mshr_p = 4);
    import bp_cce_mshr_bank_pkg::*;

    localparam int id_width_lp  = $clog2(num_mshr_p);
    localparam int cnt_width_lp = $clog2(num_mshr_p + 1);

    // Allocation is a valid/ready handshake: an entry is taken on a clock edge
    // where alloc_v_i & alloc_ready_o; alloc_ready_o never depends on alloc_v_i.
    // Enabled flags are all written with w_data_i[0].
    logic                         alloc_v_i;
    logic                         alloc_ready_o;
    logic [id_width_lp-1:0]       alloc_id_o;
    logic [lce_id_width_p-1:0]    alloc_lce_id_i;
    logic [paddr_width_p-1:0]     alloc_paddr_i;
    logic [lce_assoc_width_p-1:0] alloc_lru_way_i;
    logic [num_flags_p-1:0]       alloc_flags_i;
    logic [id_width_lp-1:0]       sel_id_i;
    logic                         stall_i;
    logic [mshr_fields_lp-1:0]    w_mask_i;
    logic [num_flags_p-1:0]       flag_w_mask_i;
    logic [data_width_p-1:0]      w_data_i;
    logic                         lru_v_i;
    logic [paddr_width_p-1:0]     lru_paddr_i;
    bp_coh_states_e               lru_coh_state_i;
    logic                         free_v_i;
    logic [id_width_lp-1:0]       free_id_i;
    logic [paddr_width_p-1:0]     lookup_paddr_i;
    logic                         lookup_hit_o;
    logic [id_width_lp-1:0]       lookup_id_o;
    bp_cce_mshr_s                 mshr_o;
    logic [num_mshr_p-1:0]        valid_o;
    logic [cnt_width_lp-1:0]      count_o;

    modport master (
        output alloc_v_i, alloc_lce_id_i, alloc_paddr_i, alloc_lru_way_i, alloc_flags_i,
        output sel_id_i, stall_i, w_mask_i, flag_w_mask_i, w_data_i,
        output lru_v_i, lru_paddr_i, lru_coh_state_i, free_v_i, free_id_i, lookup_paddr_i,
        input  alloc_ready_o, alloc_id_o, lookup_hit_o, lookup_id_o, mshr_o, valid_o, count_o
    );

    modport slave (
        input  alloc_v_i, alloc_lce_id_i, alloc_paddr_i, alloc_lru_way_i, alloc_flags_i,
        input  sel_id_i, stall_i, w_mask_i, flag_w_mask_i, w_data_i,
        input  lru_v_i, lru_paddr_i, lru_coh_state_i, free_v_i, free_id_i, lookup_paddr_i,
        output alloc_ready_o, alloc_id_o, lookup_hit_o, lookup_id_o, mshr_o, valid_o, count_o
    );

endinterface

// File: rtl/bp_cce_mshr_bank_penc.sv
// Lowest-index priority encoder used for free-entry pick and CAM hit encoding.
module bp_cce_mshr_bank_penc #(
    parameter int width_p    = 4,
    parameter int lg_width_p = $clog2(width_p)
) (
    input  logic [width_p-1:0]    i_req,
    output logic [lg_width_p-1:0] o_addr,
    output logic                  o_v
);

    always_comb begin
        o_addr = '0;
        o_v    = |i_req;
        for (int k = width_p - 1; k >= 0; k--) begin
            if (i_req[k]) o_addr = lg_width_p'(k);
        end
    end

endmodule

// File: rtl/bp_cce_mshr_bank.sv
// Multi-entry MSHR storage: allocate/free, masked per-field writes to the
// selected entry, and a block-aligned address CAM for conflict detection.
module bp_cce_mshr_bank
    import bp_cce_mshr_bank_pkg::*;
#(
    parameter int num_mshr_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_cce_mshr_bank_if.slave  bus
);

    localparam int id_w_lp  = $clog2(num_mshr_p);
    localparam int cnt_w_lp = $clog2(num_mshr_p + 1);

    logic [num_mshr_p-1:0] r_valid;
    bp_cce_mshr_s          r_mshr [num_mshr_p];
    logic [cnt_w_lp-1:0]   r_count;

    logic [num_mshr_p-1:0] w_valid_n;
    bp_cce_mshr_s          w_mshr_n [num_mshr_p];
    bp_cce_mshr_s          w_ent;
    logic [num_mshr_p-1:0] w_match;
    logic                  w_alloc;
    logic                  w_free;
    logic                  w_wr_ok;
    logic                  w_unused;

    bp_cce_mshr_bank_penc #(.width_p(num_mshr_p)) u_free_penc (
        .i_req  (~r_valid),
        .o_addr (bus.alloc_id_o),
        .o_v    (bus.alloc_ready_o)
    );

    always_comb begin
        for (int i = 0; i < num_mshr_p; i++) begin
            w_match[i] = r_valid[i] &
                (r_mshr[i].paddr[paddr_width_p-1:block_offset_width_p] ==
                 bus.lookup_paddr_i[paddr_width_p-1:block_offset_width_p]);
        end
    end

    bp_cce_mshr_bank_penc #(.width_p(num_mshr_p)) u_lookup_penc (
        .i_req  (w_match),
        .o_addr (bus.lookup_id_o),
        .o_v    (bus.lookup_hit_o)
    );

    assign bus.mshr_o  = r_mshr[bus.sel_id_i];
    assign bus.valid_o = r_valid;
    assign bus.count_o = r_count;
    assign w_unused    = ^{bus.w_data_i[data_width_p-1:paddr_width_p],
                           bus.lookup_paddr_i[block_offset_width_p-1:0]};

    // Ordering gives the tie-breaks: free beats a write, allocation beats both.
    always_comb begin
        w_alloc   = bus.alloc_v_i & bus.alloc_ready_o;
        w_free    = bus.free_v_i & r_valid[bus.free_id_i];
        w_wr_ok   = r_valid[bus.sel_id_i] & ~(w_free & (bus.free_id_i == bus.sel_id_i));
        w_valid_n = r_valid;
        w_mshr_n  = r_mshr;
        w_ent     = r_mshr[bus.sel_id_i];

        if (w_wr_ok && !bus.stall_i) begin
            if (field_en(bus.w_mask_i, e_mshr_lce))       w_ent.lce_id          = bus.w_data_i[lce_id_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_paddr))     w_ent.paddr           = bus.w_data_i[paddr_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_way))       w_ent.way_id          = bus.w_data_i[lce_assoc_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_lru_way))   w_ent.lru_way_id      = bus.w_data_i[lce_assoc_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_lru_paddr)) w_ent.lru_paddr       = bus.w_data_i[paddr_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_lru_coh))   w_ent.lru_coh_state   = bp_coh_states_e'(bus.w_data_i[2:0]);
            if (field_en(bus.w_mask_i, e_mshr_owner_lce)) w_ent.owner_lce_id    = bus.w_data_i[lce_id_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_owner_way)) w_ent.owner_way_id    = bus.w_data_i[lce_assoc_width_p-1:0];
            if (field_en(bus.w_mask_i, e_mshr_owner_coh)) w_ent.owner_coh_state = bp_coh_states_e'(bus.w_data_i[2:0]);
            if (field_en(bus.w_mask_i, e_mshr_next_coh))  w_ent.next_coh_state  = bp_coh_states_e'(bus.w_data_i[2:0]);
            if (field_en(bus.w_mask_i, e_mshr_msg_size))  w_ent.msg_size        = bus.w_data_i[msg_size_width_lp-1:0];
            for (int j = 0; j < num_flags_p; j++) begin
                if (bus.flag_w_mask_i[j]) w_ent.flags[j] = bus.w_data_i[0];
            end
        end
        // Directory LRU updates land even during a ucode stall.
        if (w_wr_ok && bus.lru_v_i) begin
            w_ent.lru_paddr     = bus.lru_paddr_i;
            w_ent.lru_coh_state = bus.lru_coh_state_i;
        end
        w_mshr_n[bus.sel_id_i] = w_ent;

        if (w_free) w_valid_n[bus.free_id_i] = 1'b0;
        if (w_alloc) begin
            w_valid_n[bus.alloc_id_o] = 1'b1;
            w_mshr_n[bus.alloc_id_o]  = mshr_init(bus.alloc_lce_id_i, bus.alloc_paddr_i,
                                                  bus.alloc_lru_way_i, bus.alloc_flags_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < num_mshr_p; i++) r_mshr[i] <= mshr_init('0, '0, '0, '0);
        end else begin
            r_valid <= w_valid_n;
            r_mshr  <= w_mshr_n;
            if (w_alloc && !w_free)      r_count <= r_count + cnt_w_lp'(1);
            else if (!w_alloc && w_free) r_count <= r_count - cnt_w_lp'(1);
        end
    end

    a_free_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.free_v_i |-> r_valid[bus.free_id_i]);

endmodule
